// File: rtl/taint_data_mem.sv
// taint_data_mem: word-addressed 32-bit data memory with a bit-level taint
// shadow array, a parameterised grant latency and memory-mapped stop/trap
// registers.
// Optional feature: define TAINT_ADDR_PROP_EN to let a tainted address taint
// the data it touches (all-ones read taint / all-ones write taint on strobed
// bits). Without it, address taint only raises addr_tainted_o.
module taint_data_mem #(
    parameter int Depth      = 32768,
    parameter int GntLatency = 0,
    parameter int StopAddr   = 0,
    parameter int TrapAddr   = 8,
    localparam int Aw        = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [31:0]   strb_i,
    input  logic          req_t0_i,
    input  logic          we_t0_i,
    input  logic [Aw-1:0] addr_t0_i,
    input  logic [31:0]   wdata_t0_i,
    input  logic [31:0]   strb_t0_i,
    output logic          gnt_o,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic [31:0]   rdata_t0_o,
    output logic          gnt_t0_o,
    output logic          stop_o,
    output logic          trap_o,
    output logic          stop_tainted_o,
    output logic          taint_seen_o,
    output logic          addr_tainted_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    localparam logic [2:0]    LatM1 = (GntLatency > 0) ? 3'(GntLatency - 1) : 3'd0;
    localparam logic [Aw-1:0] StopA = Aw'(StopAddr);
    localparam logic [Aw-1:0] TrapA = Aw'(TrapAddr);

    // Storage: data words, shadow taint words, and a per-word "taint written
    // since reset" bit so that reset clears the whole shadow array at once.
    logic [31:0]      r_mem  [Depth];
    logic [31:0]      r_tmem [Depth];
    logic [Depth-1:0] r_tvld;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_gnt;

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_rdata_t0;
    logic        r_stop;
    logic        r_trap;
    logic        r_stop_tainted;
    logic        r_taint_seen;
    logic        r_addr_tainted;

    logic        w_wr;
    logic        w_rd;
    logic        w_is_stop;
    logic        w_is_trap;
    logic        w_wr_mem;
    logic        w_ctl_taint;
    logic        w_addr_prop;
    logic [31:0] w_force;
    logic [31:0] w_tmem_old;
    logic [31:0] w_tmem_new;
    logic [31:0] w_mem_new;
    logic [31:0] w_rd_t0;
    logic        w_unused_ok;

    // Request taint has no data consequence in this memory.
    assign w_unused_ok = req_t0_i;

    // Next-state and grant decode; GRANT accepts a new request like IDLE so
    // zero-latency back-to-back accesses are granted every cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        case (r_state)
            ST_IDLE, ST_GRANT: begin
                if (req_i) begin
                    if (GntLatency == 0) begin
                        w_gnt       = 1'b1;
                        w_state_nxt = ST_GRANT;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LatM1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (r_cnt == 3'd0) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Address-taint propagation selection.
    always_comb begin
`ifdef TAINT_ADDR_PROP_EN
        w_addr_prop = |addr_t0_i;
`else
        w_addr_prop = 1'b0;
`endif
    end

    // Access decode and taint merge for the granted access.
    always_comb begin
        w_wr        = w_gnt & ~rst_i & we_i;
        w_rd        = w_gnt & ~rst_i & ~we_i;
        w_is_stop   = (addr_i == StopA);
        w_is_trap   = (addr_i == TrapA);
        w_wr_mem    = w_wr & ~w_is_stop & ~w_is_trap;
        w_ctl_taint = we_t0_i | (|strb_t0_i);
        w_force     = {32{w_ctl_taint | w_addr_prop}};
        if (r_tvld[addr_i]) begin
            w_tmem_old = r_tmem[addr_i];
        end else begin
            w_tmem_old = 32'd0;
        end
        w_tmem_new  = (w_tmem_old & ~strb_i) | ((wdata_t0_i | w_force) & strb_i);
        w_mem_new   = (r_mem[addr_i] & ~strb_i) | (wdata_i & strb_i);
        w_rd_t0     = w_tmem_old | w_force;
    end

    // Data and shadow arrays: not reset, written only by a granted write.
    always_ff @(posedge clk_i) begin
        if (w_wr_mem) begin
            r_mem[addr_i]  <= w_mem_new;
            r_tmem[addr_i] <= w_tmem_new;
        end
    end

    // Shadow-valid bits: reset makes every taint word read as zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tvld <= {Depth{1'b0}};
        end else if (w_wr_mem) begin
            r_tvld[addr_i] <= 1'b1;
        end else begin
            r_tvld <= r_tvld;
        end
    end

    // Read response registers and sticky status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid       <= 1'b0;
            r_rdata        <= 32'd0;
            r_rdata_t0     <= 32'd0;
            r_stop         <= 1'b0;
            r_trap         <= 1'b0;
            r_stop_tainted <= 1'b0;
            r_taint_seen   <= 1'b0;
            r_addr_tainted <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata    <= r_mem[addr_i];
                r_rdata_t0 <= w_rd_t0;
            end
            if (w_rd && (|w_rd_t0)) begin
                r_taint_seen <= 1'b1;
            end
            if (w_wr && w_is_stop) begin
                r_stop <= 1'b1;
                if (|wdata_t0_i) begin
                    r_stop_tainted <= 1'b1;
                end
            end
            if (w_wr && w_is_trap) begin
                r_trap <= 1'b1;
            end
            if ((w_wr || w_rd) && (|addr_t0_i)) begin
                r_addr_tainted <= 1'b1;
            end
        end
    end

    assign gnt_o          = w_gnt & ~rst_i;
    assign gnt_t0_o       = 1'b0;
    assign rvalid_o       = r_rvalid;
    assign rdata_o        = r_rdata;
    assign rdata_t0_o     = r_rdata_t0;
    assign stop_o         = r_stop;
    assign trap_o         = r_trap;
    assign stop_tainted_o = r_stop_tainted;
    assign taint_seen_o   = r_taint_seen;
    assign addr_tainted_o = r_addr_tainted;

endmodule

// File: tb/tb_taint_data_mem.sv
// Bench for taint_data_mem: one zero-latency instance and one latency-3
// instance sharing the request bus; read results go through per-instance
// expectation queues checked when rvalid_o appears.
module tb_taint_data_mem;

    localparam int Depth = 1024;
    localparam int Aw    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_a, req_b, we, req_t0, we_t0;
    logic [Aw-1:0] addr, addr_t0;
    logic [31:0]   wdata, strb, wdata_t0, strb_t0;

    logic        a_gnt, a_rvalid, a_gnt_t0, a_stop, a_trap, a_stop_t, a_tseen, a_atnt;
    logic [31:0] a_rdata, a_rdata_t0;
    logic        b_gnt, b_rvalid, b_gnt_t0, b_stop, b_trap, b_stop_t, b_tseen, b_atnt;
    logic [31:0] b_rdata, b_rdata_t0;

    taint_data_mem #(.Depth(Depth), .GntLatency(0), .StopAddr(0), .TrapAddr(8)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .strb_i(strb), .req_t0_i(req_t0), .we_t0_i(we_t0),
        .addr_t0_i(addr_t0), .wdata_t0_i(wdata_t0), .strb_t0_i(strb_t0),
        .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .rdata_t0_o(a_rdata_t0),
        .gnt_t0_o(a_gnt_t0), .stop_o(a_stop), .trap_o(a_trap), .stop_tainted_o(a_stop_t),
        .taint_seen_o(a_tseen), .addr_tainted_o(a_atnt));

    taint_data_mem #(.Depth(Depth), .GntLatency(3), .StopAddr(0), .TrapAddr(8)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .strb_i(strb), .req_t0_i(req_t0), .we_t0_i(we_t0),
        .addr_t0_i(addr_t0), .wdata_t0_i(wdata_t0), .strb_t0_i(strb_t0),
        .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .rdata_t0_o(b_rdata_t0),
        .gnt_t0_o(b_gnt_t0), .stop_o(b_stop), .trap_o(b_trap), .stop_tainted_o(b_stop_t),
        .taint_seen_o(b_tseen), .addr_tainted_o(b_atnt));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] t;
        bit          cap;
        int          slot;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] cap_val [4];

`ifdef TAINT_ADDR_PROP_EN
    localparam logic [31:0] AddrRdT0_4  = 32'hFFFF_FFFF;
    localparam logic [31:0] AddrWrT0_40 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] AddrRdT0_4  = 32'h0000_00FF;
    localparam logic [31:0] AddrWrT0_40 = 32'h0000_0000;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Read-response scoreboard for instance A.
    always @(negedge clk) begin
        exp_t e;
        if (a_rvalid === 1'b1) begin
            if (q_a.size() == 0) begin
                chk1("a_unexpected_rvalid", a_rvalid, 1'b0);
            end else begin
                e = q_a.pop_front();
                if (e.cap) cap_val[e.slot] = a_rdata;
                else chk("a_rdata", a_rdata, e.d);
                chk("a_rdata_t0", a_rdata_t0, e.t);
            end
        end
    end

    // Read-response scoreboard for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (b_rvalid === 1'b1) begin
            if (q_b.size() == 0) begin
                chk1("b_unexpected_rvalid", b_rvalid, 1'b0);
            end else begin
                e = q_b.pop_front();
                chk("b_rdata", b_rdata, e.d);
                chk("b_rdata_t0", b_rdata_t0, e.t);
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0; we = 1'b0;
        we_t0 = 1'b0; addr_t0 = '0; wdata_t0 = 32'd0; strb_t0 = 32'd0;
    endtask

    task automatic wr_a(input logic [Aw-1:0] a, input logic [31:0] d, input logic [31:0] s,
                        input logic [31:0] dt, input logic wt, input logic [Aw-1:0] at);
        @(posedge clk); #1;
        req_a = 1'b1; req_b = 1'b0; we = 1'b1; addr = a; wdata = d; strb = s;
        wdata_t0 = dt; we_t0 = wt; addr_t0 = at; strb_t0 = 32'd0;
        @(negedge clk);
        chk1("a_wr_gnt", a_gnt, 1'b1);
    endtask

    task automatic rd_a(input logic [Aw-1:0] a, input logic [31:0] st, input logic [Aw-1:0] at,
                        input logic [31:0] ed, input logic [31:0] et, input bit cap, input int slot);
        exp_t e;
        @(posedge clk); #1;
        req_a = 1'b1; req_b = 1'b0; we = 1'b0; addr = a; strb = 32'd0;
        wdata_t0 = 32'd0; we_t0 = 1'b0; addr_t0 = at; strb_t0 = st;
        @(negedge clk);
        chk1("a_rd_gnt", a_gnt, 1'b1);
        e.d = ed; e.t = et; e.cap = cap; e.slot = slot;
        q_a.push_back(e);
    endtask

    task automatic rd_b(input logic [Aw-1:0] a, input logic [31:0] ed, input logic [31:0] et);
        exp_t e;
        int   n;
        n = 0;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b1; we = 1'b0; addr = a; strb = 32'd0;
        wdata_t0 = 32'd0; we_t0 = 1'b0; addr_t0 = '0; strb_t0 = 32'd0;
        @(negedge clk);
        while (b_gnt !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1("b_rd_gnt", b_gnt, 1'b1);
        if (b_gnt === 1'b1) begin
            e.d = ed; e.t = et; e.cap = 1'b0; e.slot = 0;
            q_b.push_back(e);
        end
        idle();
    endtask

    task automatic chk_flags_zero(input string pfx);
        chk1({pfx, "_a_stop"}, a_stop, 1'b0);
        chk1({pfx, "_a_trap"}, a_trap, 1'b0);
        chk1({pfx, "_a_stop_t"}, a_stop_t, 1'b0);
        chk1({pfx, "_a_tseen"}, a_tseen, 1'b0);
        chk1({pfx, "_a_atnt"}, a_atnt, 1'b0);
        chk1({pfx, "_b_stop"}, b_stop, 1'b0);
        chk1({pfx, "_b_trap"}, b_trap, 1'b0);
        chk1({pfx, "_b_atnt"}, b_atnt, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; req_t0 = 1'b0; we_t0 = 1'b0;
        addr = '0; addr_t0 = '0; wdata = 32'd0; strb = 32'd0; wdata_t0 = 32'd0; strb_t0 = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_a_rvalid", a_rvalid, 1'b0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_a_rdata_t0", a_rdata_t0, 32'd0);
        chk1("rst_a_gnt_t0", a_gnt_t0, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        chk1("rst_b_rvalid", b_rvalid, 1'b0);
        chk_flags_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Capture the never-writable stop/trap words
        rd_a(10'h000, 32'd0, '0, 32'd0, 32'd0, 1'b1, 0);
        rd_a(10'h008, 32'd0, '0, 32'd0, 32'd0, 1'b1, 1);

        // Zero-latency write then read-back in consecutive grants
        wr_a(10'h010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0, 1'b0, '0);
        chk1("a_gnt_t0", a_gnt_t0, 1'b0);
        rd_a(10'h010, 32'd0, '0, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);

        // Partial strobe merge
        wr_a(10'h020, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 1'b0, '0);
        wr_a(10'h020, 32'hAABB_CCDD, 32'h0000_FF00, 32'd0, 1'b0, '0);
        rd_a(10'h020, 32'd0, '0, 32'h1234_CC78, 32'd0, 1'b0, 0);
        idle();
        chk1("a_tseen_before", a_tseen, 1'b0);

        // Data taint under partial strobe
        wr_a(10'h004, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, '0);
        wr_a(10'h004, 32'hABCD_1234, 32'h0000_FFFF, 32'h0000_00FF, 1'b0, '0);
        rd_a(10'h004, 32'd0, '0, 32'h0000_1234, 32'h0000_00FF, 1'b0, 0);
        idle();
        chk1("a_tseen_after", a_tseen, 1'b1);

        // Tainted write enable taints every strobed bit; tainted strobe on read taints all
        wr_a(10'h030, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, '0);
        wr_a(10'h030, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd0, 1'b1, '0);
        rd_a(10'h030, 32'd0, '0, 32'h000F_000F, 32'h00FF_00FF, 1'b0, 0);
        rd_a(10'h010, 32'h0000_0001, '0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 0);
        idle();
        chk1("a_stop_before", a_stop, 1'b0);
        chk1("a_trap_before", a_trap, 1'b0);

        // Stop / trap registers
        wr_a(10'h000, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'd1, 1'b0, '0);
        wr_a(10'h008, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'd0, 1'b0, '0);
        wr_a(10'h000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, '0);
        idle();
        chk1("a_stop", a_stop, 1'b1);
        chk1("a_stop_tainted", a_stop_t, 1'b1);
        chk1("a_trap", a_trap, 1'b1);
        rd_a(10'h000, 32'd0, '0, cap_val[0], 32'd0, 1'b0, 0);
        rd_a(10'h008, 32'd0, '0, cap_val[1], 32'd0, 1'b0, 0);
        idle();
        chk1("a_atnt_before", a_atnt, 1'b0);

        // Address taint
        rd_a(10'h004, 32'd0, 10'h001, 32'h0000_1234, AddrRdT0_4, 1'b0, 0);
        idle();
        chk1("a_atnt_after", a_atnt, 1'b1);
        wr_a(10'h040, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 1'b0, 10'h001);
        rd_a(10'h040, 32'd0, '0, 32'h0000_0001, AddrWrT0_40, 1'b0, 0);
        idle();

        // Latency 3: grant exactly in cycle 3 after the request
        @(posedge clk); #1;
        req_b = 1'b1; we = 1'b1; addr = 10'h050; wdata = 32'h1111_1111; strb = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("b_gnt_cycle%0d", c), b_gnt, (c == 3));
        end
        idle();

        // Request dropped in WAIT: no grant, no write
        @(posedge clk); #1;
        req_b = 1'b1; we = 1'b1; addr = 10'h050; wdata = 32'h9999_9999; strb = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_b = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | b_gnt;
        end
        chk1("b_abort_no_gnt", seen, 1'b0);
        rd_b(10'h050, 32'h1111_1111, 32'd0);

        // Reset in the middle of WAIT during a write
        @(posedge clk); #1;
        req_b = 1'b1; we = 1'b1; addr = 10'h050; wdata = 32'h7777_7777; strb = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | b_gnt;
        end
        @(posedge clk); #1;
        req_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | b_gnt;
        end
        chk1("b_rst_no_gnt", seen, 1'b0);
        chk_flags_zero("post_rst");
        rd_b(10'h050, 32'h1111_1111, 32'd0);
        rd_a(10'h004, 32'd0, '0, 32'h0000_1234, 32'd0, 1'b0, 0);
        rd_a(10'h010, 32'd0, '0, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        repeat (3) idle();

        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
